sub16_serial: RTL and testbench

Sequential 16-bit subtractor, the inverse of the combinational 16-bit adder in the arithmetic units. It computes `diff = x - y - bin` and a borrow-out over `WIDTH/STEP` clock cycles, processing `STEP` bits per cycle from the LSB up, with a start/busy/done handshake. It sits beside the adder in the arithmetic-unit library and serves area-constrained datapaths that trade latency for a narrow subtract slice.

---
 rtl/arith_pkg.sv | 13 +
 rtl/full_sub.sv | 13 +
 rtl/sub16_serial.sv | 98 +++++++++
 tb/tb_sub16_serial.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for the arithmetic-unit library
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_WIDTH = 16;

  // Step counter must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - 1-bit full subtractor cell, counterpart of the adder's full-adder cell
module full_sub (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ br;
  assign bo = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/sub16_serial.sv
// rtl/sub16_serial.sv - sequential subtractor, STEP bits per cycle from the LSB up
module sub16_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_width(N);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     xs_q, ys_q, res_q, diff_q;
  logic                 br_q, bout_q, busy_q, done_q;

  logic [STEP:0]        chain_d;
  logic [STEP-1:0]      dstep_d;
  logic [WIDTH+STEP-1:0] cat_d;
  logic [WIDTH-1:0]     res_d;
  logic                 last_d;

  assign chain_d[0] = br_q;

  for (genvar i = 0; i < STEP; i++) begin : g_cell
    full_sub u_fs (
      .a  (xs_q[i]),
      .b  (ys_q[i]),
      .br (chain_d[i]),
      .d  (dstep_d[i]),
      .bo (chain_d[i+1])
    );
  end

  // New result bits enter at the MSB end so the LSB slice ends up at bit 0 after N steps.
  assign cat_d  = {dstep_d, res_q};
  assign res_d  = cat_d[WIDTH+STEP-1:STEP];
  assign last_d = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN) begin
        xs_q  <= xs_q >> STEP;
        ys_q  <= ys_q >> STEP;
        res_q <= res_d;
        br_q  <= chain_d[STEP];
        cnt_q <= cnt_q + CW'(1);
        if (last_d) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          diff_q  <= res_d;
          bout_q  <= chain_d[STEP];
        end
      end else if (start) begin
        // IDLE and DONE both accept a new request; DONE gives back-to-back throughput.
        state_q <= RUN;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        xs_q    <= x;
        ys_q    <= y;
        br_q    <= bin;
        res_q   <= '0;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_sub16_serial.sv
// tb/tb_sub16_serial.sv - directed self-checking bench for sub16_serial (STEP=1 and STEP=4)
module tb_sub16_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [15:0] x, y;
  logic        bin;
  logic        busy1, done1, bout1;
  logic        busy4, done4, bout4;
  logic [15:0] diff1, diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub16_serial #(.WIDTH(16), .STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .x(x), .y(y), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  sub16_serial #(.WIDTH(16), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .x(x), .y(y), .bin(bin),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  // Issues one request and returns at the negedge where done is seen (or lat=-1 on timeout).
  task automatic run_op(input logic [15:0] xa, input logic [15:0] ya, input logic ba,
                        input bit use4, output logic [15:0] d, output logic bo,
                        output int busy_n, output int lat);
    @(negedge clk);
    x = xa; y = ya; bin = ba;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    lat = 1; busy_n = 0;
    while (!(use4 ? done4 : done1) && lat < 100) begin
      if (use4 ? busy4 : busy1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) lat = -1;
    d  = use4 ? diff4 : diff1;
    bo = use4 ? bout4 : bout1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; x = 16'h0; y = 16'h0; bin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, diff1, bout1} !== 19'h0) begin
      errors++;
      $display("FAIL reset_step1: got busy=%b done=%b diff=%h bout=%b, want all 0", busy1, done1, diff1, bout1);
    end
    checks++;
    if ({busy4, done4, diff4, bout4} !== 19'h0) begin
      errors++;
      $display("FAIL reset_step4: got busy=%b done=%b diff=%h bout=%b, want all 0", busy4, done4, diff4, bout4);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] d; logic bo; int bn, lat;
    run_op(16'h0000, 16'h5555, 1'b0, 1'b0, d, bo, bn, lat);
    checks++;
    if (d !== 16'hAAAB || bo !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: got diff=%h bout=%b, want AAAB 1", d, bo);
    end
    checks++;
    if (bn !== 16) begin errors++; $display("FAIL basic_busy_len: got %0d, want 16", bn); end
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL basic_latency: got %0d, want 17", lat); end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b, want 0", busy1); end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b, want 0", done1); end
  endtask

  task automatic test_borrow_in;
    logic [15:0] d; logic bo; int bn, lat;
    run_op(16'h0000, 16'h5555, 1'b1, 1'b0, d, bo, bn, lat);
    checks++;
    if (d !== 16'hAAAA || bo !== 1'b1) begin
      errors++;
      $display("FAIL bin_result: got diff=%h bout=%b, want AAAA 1", d, bo);
    end
    run_op(16'h9112, 16'hFFFF, 1'b0, 1'b0, d, bo, bn, lat);
    checks++;
    if (d !== 16'h9113 || bo !== 1'b1) begin
      errors++;
      $display("FAIL wrap_result: got diff=%h bout=%b, want 9113 1", d, bo);
    end
  endtask

  task automatic test_hold;
    logic [15:0] d; logic bo; int bn, lat;
    run_op(16'hFFFF, 16'h9112, 1'b1, 1'b0, d, bo, bn, lat);
    checks++;
    if (d !== 16'h6EEC || bo !== 1'b0) begin
      errors++;
      $display("FAIL hold_result: got diff=%h bout=%b, want 6EEC 0", d, bo);
    end
    x = 16'h1111; y = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (diff1 !== 16'h6EEC || done1 !== 1'b0) begin
        errors++;
        $display("FAIL hold_idle%0d: got diff=%h done=%b, want 6EEC 0", i, diff1, done1);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    x = 16'h1234; y = 16'h0001; bin = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    x = 16'h0000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (lat >= 100) begin errors++; $display("FAIL busy_start_timeout: got no done, want done"); end
    checks++;
    if (diff1 !== 16'h1233 || bout1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_result: got diff=%h bout=%b, want 1233 0", diff1, bout1);
    end
  endtask

  task automatic test_reset_abort;
    logic [15:0] d; logic bo; int bn, lat, seen;
    @(negedge clk);
    x = 16'h00FF; y = 16'h0001; bin = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy1, done1, diff1, bout1} !== 19'h0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b diff=%h bout=%b, want all 0", busy1, done1, diff1, bout1);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done cycles, want 0", seen); end
    run_op(16'h0010, 16'h0001, 1'b0, 1'b0, d, bo, bn, lat);
    checks++;
    if (d !== 16'h000F || bo !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL abort_recover: got diff=%h bout=%b lat=%0d, want 000F 0 17", d, bo, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d; logic bo; int bn, lat;
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0, d, bo, bn, lat);
    checks++;
    if (d !== 16'h0002 || bo !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got diff=%h bout=%b, want 0002 0", d, bo);
    end
    x = 16'h0001; y = 16'h0002; bin = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy1, done1);
    end
    lat = 1;
    while (!done1 && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 17 || diff1 !== 16'hFFFF || bout1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got diff=%h bout=%b lat=%0d, want FFFF 1 17", diff1, bout1, lat);
    end
  endtask

  task automatic test_step4;
    logic [15:0] d; logic bo; int bn, lat;
    run_op(16'h0000, 16'h5555, 1'b0, 1'b1, d, bo, bn, lat);
    checks++;
    if (d !== 16'hAAAB || bo !== 1'b1 || bn !== 4 || lat !== 5) begin
      errors++;
      $display("FAIL step4_op1: got diff=%h bout=%b busy=%0d lat=%0d, want AAAB 1 4 5", d, bo, bn, lat);
    end
    run_op(16'h0000, 16'h5555, 1'b1, 1'b1, d, bo, bn, lat);
    checks++;
    if (d !== 16'hAAAA || bo !== 1'b1) begin
      errors++;
      $display("FAIL step4_op2: got diff=%h bout=%b, want AAAA 1", d, bo);
    end
    run_op(16'h9112, 16'hFFFF, 1'b0, 1'b1, d, bo, bn, lat);
    checks++;
    if (d !== 16'h9113 || bo !== 1'b1) begin
      errors++;
      $display("FAIL step4_op3: got diff=%h bout=%b, want 9113 1", d, bo);
    end
    run_op(16'hFFFF, 16'h9112, 1'b1, 1'b1, d, bo, bn, lat);
    checks++;
    if (d !== 16'h6EEC || bo !== 1'b0 || lat !== 5) begin
      errors++;
      $display("FAIL step4_op4: got diff=%h bout=%b lat=%0d, want 6EEC 0 5", d, bo, lat);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow_in;
    test_hold;
    test_start_while_busy;
    test_reset_abort;
    test_back_to_back;
    test_step4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
